// File: rtl/wb_regfile.sv
// wb_regfile: general-purpose register file at the consumer end of the
// MEM/WB writeback path, with a load-pending scoreboard.
//
// Ports:
//   clk, rst               clock (rising edge), synchronous active-high reset
//   wb_wreg/wb_wd/wb_wdata writeback port (enable, address, data)
//   re1/raddr1 -> rdata1   read port 1, combinational, write-first bypass
//   re2/raddr2 -> rdata2   read port 2, combinational, write-first bypass
//   ld_issue/ld_wd         ID issues a load to ld_wd this cycle
//   flush                  cancels every pending load
//   stall_req              load-use hazard on either read port, combinational
//   busy                   registered scoreboard vector (bit 0 always 0)
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREG   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_wreg,
  input  logic [ADDR_W-1:0] wb_wd,
  input  logic [DATA_W-1:0] wb_wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  input  logic              ld_issue,
  input  logic [ADDR_W-1:0] ld_wd,
  input  logic              flush,
  output logic              stall_req,
  output logic [NREG-1:0]   busy
);

  logic [DATA_W-1:0] regs [NREG];
  logic [NREG-1:0]   busy_next;
  logic              stall1, stall2;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wb_wreg && (wb_wd != '0)) begin
      regs[wb_wd] <= wb_wdata;
    end
  end

  // A load issued this cycle outranks a same-cycle writeback to the same
  // register: the older value being written back is already stale.
  always_comb begin
    busy_next = busy;
    for (int i = 1; i < NREG; i++) begin
      if (flush)
        busy_next[i] = 1'b0;
      else if (ld_issue && (ld_wd == ADDR_W'(i)))
        busy_next[i] = 1'b1;
      else if (wb_wreg && (wb_wd == ADDR_W'(i)))
        busy_next[i] = 1'b0;
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= busy_next;
  end

  function automatic logic [DATA_W-1:0] read_port(input logic re,
                                                  input logic [ADDR_W-1:0] raddr);
    if (rst || !re || (raddr == '0))
      return '0;
    else if (wb_wreg && (wb_wd == raddr))
      return wb_wdata;
    else
      return regs[raddr];
  endfunction

  // A writeback landing this cycle satisfies the reader via bypass.
  function automatic logic hazard(input logic re, input logic [ADDR_W-1:0] raddr);
    return re && (raddr != '0) && busy[raddr] && !(wb_wreg && (wb_wd == raddr));
  endfunction

  always_comb begin
    rdata1    = read_port(re1, raddr1);
    rdata2    = read_port(re2, raddr2);
    stall1    = hazard(re1, raddr1);
    stall2    = hazard(re2, raddr2);
    stall_req = !rst && (stall1 || stall2);
  end

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed self-checking bench for wb_regfile.
module tb_wb_regfile;
  logic        clk = 1'b0;
  logic        rst;
  logic        wb_wreg;
  logic [4:0]  wb_wd;
  logic [31:0] wb_wdata;
  logic        re1, re2;
  logic [4:0]  raddr1, raddr2;
  logic [31:0] rdata1, rdata2;
  logic        ld_issue;
  logic [4:0]  ld_wd;
  logic        flush;
  logic        stall_req;
  logic [31:0] busy;

  int checks = 0;
  int errors = 0;

  wb_regfile dut (
    .clk(clk), .rst(rst),
    .wb_wreg(wb_wreg), .wb_wd(wb_wd), .wb_wdata(wb_wdata),
    .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
    .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
    .ld_issue(ld_issue), .ld_wd(ld_wd), .flush(flush),
    .stall_req(stall_req), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb_wreg = 0; wb_wd = 0; wb_wdata = 0;
    re1 = 0; raddr1 = 0; re2 = 0; raddr2 = 0;
    ld_issue = 0; ld_wd = 0; flush = 0;
  endtask

  initial begin
    idle();
    // 1. reset with a write pending
    rst = 1; wb_wreg = 1; wb_wd = 5; wb_wdata = 32'hDEADBEEF;
    re1 = 1; raddr1 = 5; re2 = 1; raddr2 = 5; ld_issue = 1; ld_wd = 5;
    #1;
    chk("rst_rdata1_c0", rdata1, 0);
    chk("rst_rdata2_c0", rdata2, 0);
    chk("rst_stall_c0", stall_req, 0);
    tick();
    chk("rst_rdata1_c1", rdata1, 0);
    chk("rst_stall_c1", stall_req, 0);
    tick();
    chk("rst_busy", busy, 0);
    rst = 0; idle(); re1 = 1; raddr1 = 5;
    #1;
    chk("rst_reg5", rdata1, 0);

    // 2. write / read / r0
    idle(); wb_wreg = 1; wb_wd = 3; wb_wdata = 32'h12345678;
    tick();
    idle(); re1 = 1; raddr1 = 3;
    #1;
    chk("rd_r3", rdata1, 32'h12345678);
    re1 = 0;
    #1;
    chk("rd_re1_off", rdata1, 0);
    wb_wreg = 1; wb_wd = 0; wb_wdata = 32'hFFFFFFFF; re2 = 1; raddr2 = 0;
    #1;
    chk("rd_r0_bypass", rdata2, 0);
    tick();
    wb_wreg = 0;
    #1;
    chk("rd_r0_after", rdata2, 0);

    // 3. bypass on both ports
    idle(); wb_wreg = 1; wb_wd = 7; wb_wdata = 32'h11;
    tick();
    wb_wdata = 32'h22; re1 = 1; raddr1 = 7; re2 = 1; raddr2 = 7;
    #1;
    chk("byp_rdata1", rdata1, 32'h22);
    chk("byp_rdata2", rdata2, 32'h22);
    tick();
    wb_wreg = 0;
    #1;
    chk("byp_stored", rdata1, 32'h22);

    // 4. load-use stall
    idle(); ld_issue = 1; ld_wd = 9; re1 = 1; raddr1 = 9;
    #1;
    chk("lu_c0_stall", stall_req, 0);
    tick();
    ld_issue = 0;
    #1;
    chk("lu_c1_stall", stall_req, 1);
    chk("lu_c1_busy9", busy[9], 1);
    tick();
    wb_wreg = 1; wb_wd = 9; wb_wdata = 32'hABCD;
    #1;
    chk("lu_c2_stall", stall_req, 0);
    chk("lu_c2_rdata1", rdata1, 32'hABCD);
    tick();
    wb_wreg = 0;
    #1;
    chk("lu_c3_busy9", busy[9], 0);
    chk("lu_c3_stall", stall_req, 0);
    chk("lu_c3_rdata1", rdata1, 32'hABCD);

    // 5. set/clear collision, load to r0
    idle(); ld_issue = 1; ld_wd = 4; wb_wreg = 1; wb_wd = 4; wb_wdata = 32'h44;
    tick();
    idle(); re2 = 1; raddr2 = 4;
    #1;
    chk("col_busy4", busy[4], 1);
    chk("col_reg4", rdata2, 32'h44);
    chk("col_stall", stall_req, 1);
    idle(); ld_issue = 1; ld_wd = 0;
    tick();
    ld_issue = 0;
    #1;
    chk("ld_r0_busy0", busy[0], 0);

    // 6a. flush with concurrent load issue
    idle(); ld_issue = 1; ld_wd = 2;
    tick();
    ld_wd = 6;
    tick();
    ld_issue = 0;
    #1;
    chk("fl_busy_pre", busy, 32'h54);
    flush = 1; ld_issue = 1; ld_wd = 8;
    tick();
    idle();
    #1;
    chk("fl_busy_post", busy, 0);
    re1 = 1; raddr1 = 2; re2 = 1; raddr2 = 6;
    #1;
    chk("fl_stall_r2r6", stall_req, 0);
    raddr1 = 8;
    #1;
    chk("fl_stall_r8", stall_req, 0);

    // 6b. reset mid-operation
    idle(); ld_issue = 1; ld_wd = 2;
    tick();
    ld_wd = 6;
    tick();
    idle(); re1 = 1; raddr1 = 6;
    #1;
    chk("rs_busy_pre", busy, 32'h44);
    chk("rs_stall_pre", stall_req, 1);
    rst = 1;
    #1;
    chk("rs_stall_in_rst", stall_req, 0);
    chk("rs_rdata_in_rst", rdata1, 0);
    tick();
    rst = 0; idle();
    #1;
    chk("rs_busy_post", busy, 0);
    re1 = 1; raddr1 = 3; re2 = 1; raddr2 = 7;
    #1;
    chk("rs_reg3", rdata1, 0);
    chk("rs_reg7", rdata2, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
